// File: rtl/ecc_scrubber_pkg.sv
// Shared types and helpers for the ECC scrubber: FSM state encoding, default
// widths and a width-agnostic saturating increment.
package ecc_scrubber_pkg;

   localparam int DEF_ADDR_WIDTH = 13;
   localparam int DEF_DATA_WIDTH = 39;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CHECK,
      S_WRITE,
      S_NEXT
   } state_e;

   // Increment v as a w-bit quantity, holding at all-ones instead of wrapping.
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
      logic [63:0] max_v;
      max_v = {64{1'b1}} >> (64 - w);
      return (v >= max_v) ? v : v + 64'd1;
   endfunction

endpackage

// File: rtl/ecc_scrubber_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter
   import ecc_scrubber_pkg::*;
#(
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   inc,
   output logic [COUNT_WIDTH-1:0] value
);

   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc) cnt_d = COUNT_WIDTH'(sat_inc(64'(cnt_q), COUNT_WIDTH));
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign value = cnt_q;

endmodule

// File: rtl/ecc_scrubber.sv
// Background ECC scrubber: walks every memory word, writes back codewords the
// external decoder can correct, and counts/logs the ones it cannot.
module ecc_scrubber
   import ecc_scrubber_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int DEPTH          = 8192,
   parameter int INTERVAL_WIDTH = 16,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [INTERVAL_WIDTH-1:0] interval,
   output logic                      mem_req,
   input  logic                      mem_gnt,
   output logic                      mem_clk_en,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic                      mem_write_en,
   output logic [DATA_WIDTH-1:0]     mem_write_data,
   input  logic [DATA_WIDTH-1:0]     mem_read_data,
   output logic [DATA_WIDTH-1:0]     dec_codeword,
   input  logic [DATA_WIDTH-1:0]     dec_corrected,
   input  logic                      dec_error,
   input  logic                      dec_uncorrectable,
   output logic [COUNT_WIDTH-1:0]    corrected_count,
   output logic [COUNT_WIDTH-1:0]    uncorrectable_count,
   output logic [ADDR_WIDTH-1:0]     last_error_addr,
   output logic                      err_pulse,
   output logic                      pass_done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   state_e                    state_q;
   logic                      eval_q;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [ADDR_WIDTH-1:0]     last_err_q;
   logic [INTERVAL_WIDTH-1:0] ivl_q;
   logic [DATA_WIDTH-1:0]     codeword_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic                      err_pulse_q;
   logic                      pass_done_q;
   logic                      corr_inc;
   logic                      uncorr_inc;

   // CHECK spans two cycles: eval_q=0 captures read data, eval_q=1 judges the decoder.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         eval_q      <= 1'b0;
         addr_q      <= '0;
         ivl_q       <= '0;
         codeword_q  <= '0;
         wdata_q     <= '0;
         last_err_q  <= '0;
         err_pulse_q <= 1'b0;
         pass_done_q <= 1'b0;
      end else begin
         err_pulse_q <= 1'b0;
         pass_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!enable) begin
                  ivl_q <= '0;
               end else if (ivl_q >= interval) begin
                  ivl_q   <= '0;
                  state_q <= S_READ;
               end else begin
                  ivl_q <= ivl_q + 1'b1;
               end
            end
            S_READ: begin
               if (mem_gnt) begin
                  eval_q  <= 1'b0;
                  state_q <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (!eval_q) begin
                  codeword_q <= mem_read_data;
                  eval_q     <= 1'b1;
               end else begin
                  eval_q <= 1'b0;
                  if (dec_uncorrectable) begin
                     last_err_q  <= addr_q;
                     err_pulse_q <= 1'b1;
                     state_q     <= S_NEXT;
                  end else if (dec_error) begin
                     wdata_q <= dec_corrected;
                     state_q <= S_WRITE;
                  end else begin
                     state_q <= S_NEXT;
                  end
               end
            end
            S_WRITE: begin
               if (mem_gnt) state_q <= S_NEXT;
            end
            S_NEXT: begin
               if (addr_q == LAST_ADDR) begin
                  addr_q      <= '0;
                  pass_done_q <= 1'b1;
               end else begin
                  addr_q <= addr_q + 1'b1;
               end
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Strobes are also gated by rst so a write cannot land on the reset edge itself.
   assign mem_req        = (state_q == S_READ) || (state_q == S_CHECK) || (state_q == S_WRITE);
   assign mem_clk_en     = ((state_q == S_READ) || (state_q == S_WRITE)) && mem_gnt && !rst;
   assign mem_write_en   = (state_q == S_WRITE) && mem_gnt && !rst;
   assign mem_addr       = addr_q;
   assign mem_write_data = wdata_q;
   assign dec_codeword   = codeword_q;
   assign last_error_addr = last_err_q;
   assign err_pulse      = err_pulse_q;
   assign pass_done      = pass_done_q;

   assign corr_inc   = (state_q == S_WRITE) && mem_gnt;
   assign uncorr_inc = (state_q == S_CHECK) && eval_q && dec_uncorrectable;

   sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_corr_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (corr_inc),
      .value (corrected_count)
   );

   sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_uncorr_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (uncorr_inc),
      .value (uncorrectable_count)
   );

endmodule

// File: tb/tb_ecc_scrubber.sv
// Scoreboard bench for ecc_scrubber: a word-level model predicts every memory
// access, error event and pass completion; a monitor pops and compares them.
module tb_ecc_scrubber;

   localparam int AW = 13;
   localparam int DW = 39;
   localparam int DEPTH = 8;
   localparam int IW = 16;
   localparam int CW = 4;
   localparam int CMAX = 15;
   localparam int K_READ = 0, K_WRITE = 1, K_ERR = 2, K_PASS = 3;

   typedef struct {
      int          kind;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int          gap;
      int          cor;
      int          unc;
   } exp_t;

   logic clk = 1'b0;
   logic rst, enable;
   logic [IW-1:0] interval;
   logic mem_req, mem_gnt, mem_clk_en, mem_write_en;
   logic [AW-1:0] mem_addr, last_error_addr;
   logic [DW-1:0] mem_write_data, mem_read_data, dec_codeword, dec_corrected;
   logic dec_error, dec_uncorrectable, err_pulse, pass_done;
   logic [CW-1:0] corrected_count, uncorrectable_count;

   logic gnt_rand = 1'b0, gnt_man = 1'b0, rnd_gnt = 1'b1;
   logic load_en = 1'b0;
   int load_addr = 0;
   logic [DW-1:0] load_data = '0;
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rd_q = '0;

   logic [DW-1:0] ref_mem [DEPTH];
   exp_t exp_q[$];
   int ref_ptr = 0, exp_cor = 0, exp_unc = 0;
   int reads_pushed = 0, reads_seen = 0;
   int checks = 0, failures = 0;
   int cyc = 0, last_rd_cyc = 0, err_cycles = 0, pass_seen = 0;
   bit mon_on = 1'b0;

   ecc_scrubber #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
      .INTERVAL_WIDTH(IW), .COUNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .interval(interval),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_clk_en(mem_clk_en),
      .mem_addr(mem_addr), .mem_write_en(mem_write_en),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .dec_codeword(dec_codeword), .dec_corrected(dec_corrected),
      .dec_error(dec_error), .dec_uncorrectable(dec_uncorrectable),
      .corrected_count(corrected_count), .uncorrectable_count(uncorrectable_count),
      .last_error_addr(last_error_addr), .err_pulse(err_pulse), .pass_done(pass_done)
   );

   always #5 clk = ~clk;

   // Codeword tag in bits [38:37]: 00 clean, 01 correctable, 1x uncorrectable
   // (11 also raises dec_error, 10 does not).
   assign dec_error         = dec_codeword[37];
   assign dec_uncorrectable = dec_codeword[38];
   assign dec_corrected     = {2'b00, dec_codeword[36:0]};
   assign mem_gnt           = gnt_rand ? rnd_gnt : gnt_man;
   assign mem_read_data     = rd_q;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_clk_en && mem_write_en) mem[mem_addr[2:0]] <= mem_write_data;
      else if (load_en)               mem[load_addr]     <= load_data;
      if (mem_clk_en && !mem_write_en) rd_q <= mem[mem_addr[2:0]];
   end

   initial forever begin
      @(posedge clk);
      #1 rnd_gnt = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic pop_cmp(input int kind);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", kind, $time);
         return;
      end
      e = exp_q.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      case (kind)
         K_READ: begin
            chk("read_addr", 64'(mem_addr), 64'(e.addr));
            if (e.gap != 0) chk("read_gap", 64'(cyc - last_rd_cyc), 64'(e.gap));
         end
         K_WRITE: begin
            chk("write_addr", 64'(mem_addr), 64'(e.addr));
            chk("write_data", 64'(mem_write_data), 64'(e.data));
         end
         K_ERR: begin
            chk("last_error_addr", 64'(last_error_addr), 64'(e.addr));
            chk("uncorr_count_at_err", 64'(uncorrectable_count), 64'(e.unc));
         end
         default: begin
            chk("corr_count_at_pass", 64'(corrected_count), 64'(e.cor));
            chk("uncorr_count_at_pass", 64'(uncorrectable_count), 64'(e.unc));
         end
      endcase
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         if (err_pulse) err_cycles++;
         if (pass_done) pass_seen++;
         if (mem_clk_en) begin
            if (!mem_write_en) reads_seen++;
            pop_cmp(mem_write_en ? K_WRITE : K_READ);
            if (!mem_write_en) last_rd_cyc = cyc;
         end
         if (err_pulse) pop_cmp(K_ERR);
         if (pass_done) pop_cmp(K_PASS);
      end
   end

   // Word-level reference: what scrubbing the next n words must produce.
   task automatic push_words(input int n, input bit gap_on);
      exp_t e;
      logic [DW-1:0] w;
      bit prev_wr;
      int a;
      prev_wr = 1'b0;
      for (int i = 0; i < n; i++) begin
         a = ref_ptr;
         w = ref_mem[a];
         e.kind = K_READ; e.addr = AW'(a); e.data = '0;
         e.gap = (gap_on && i > 0) ? (prev_wr ? 6 : 5) : 0;
         e.cor = 0; e.unc = 0;
         exp_q.push_back(e);
         reads_pushed++;
         prev_wr = 1'b0;
         if (w[38]) begin
            if (exp_unc < CMAX) exp_unc++;
            e.kind = K_ERR; e.unc = exp_unc;
            exp_q.push_back(e);
         end else if (w[37]) begin
            ref_mem[a] = {2'b00, w[36:0]};
            if (exp_cor < CMAX) exp_cor++;
            e.kind = K_WRITE; e.data = ref_mem[a];
            exp_q.push_back(e);
            prev_wr = 1'b1;
         end
         if (a == DEPTH - 1) begin
            e.kind = K_PASS; e.cor = exp_cor; e.unc = exp_unc;
            exp_q.push_back(e);
         end
         ref_ptr = (a + 1) % DEPTH;
      end
   endtask

   task automatic load(input int a, input logic [DW-1:0] w);
      load_addr = a;
      load_data = w;
      load_en = 1'b1;
      @(posedge clk);
      #1 load_en = 1'b0;
      ref_mem[a] = w;
   endtask

   function automatic logic [DW-1:0] rand_word(input int tag_sel);
      logic [36:0] d;
      d = {$urandom(), $urandom()};
      case (tag_sel)
         1: return {2'b01, d};
         2: return {2'b10, d};
         3: return {2'b11, d};
         default: return {2'b00, d};
      endcase
   endfunction

   task automatic finish_run();
      int t;
      t = 0;
      while (reads_seen < reads_pushed && t < 5000) begin
         @(posedge clk); #1 t++;
      end
      enable = 1'b0;
      while (exp_q.size() != 0 && t < 5000) begin
         @(posedge clk); #1 t++;
      end
      chk("run_complete_pending", 64'(exp_q.size()), 64'd0);
      repeat (6) @(posedge clk);
      #1 chk("idle_after_run", 64'(mem_req), 64'd0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_req"}, 64'(mem_req), 0);
      chk({tag, "_clk_en"}, 64'(mem_clk_en), 0);
      chk({tag, "_write_en"}, 64'(mem_write_en), 0);
      chk({tag, "_addr"}, 64'(mem_addr), 0);
      chk({tag, "_wdata"}, 64'(mem_write_data), 0);
      chk({tag, "_dec_cw"}, 64'(dec_codeword), 0);
      chk({tag, "_corr"}, 64'(corrected_count), 0);
      chk({tag, "_uncorr"}, 64'(uncorrectable_count), 0);
      chk({tag, "_last_err"}, 64'(last_error_addr), 0);
      chk({tag, "_err_pulse"}, 64'(err_pulse), 0);
      chk({tag, "_pass_done"}, 64'(pass_done), 0);
   endtask

   task automatic model_reset();
      exp_q.delete();
      reads_pushed = reads_seen;
      exp_cor = 0;
      exp_unc = 0;
      ref_ptr = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
   endtask

   task automatic wait_read(output bit ok);
      int t;
      t = 0;
      ok = 1'b0;
      while (!ok && t < 100) begin
         @(negedge clk);
         t++;
         if (mem_clk_en && !mem_write_en) ok = 1'b1;
      end
      chk("read_seen_in_time", 64'(ok), 64'd1);
   endtask

   initial begin
      int n, base, any, a;
      bit ok;
      logic [DW-1:0] orig;
      rst = 1'b1; enable = 1'b0; interval = '0;
      for (int i = 0; i < DEPTH; i++) load(i, {2'b00, 37'(i * 37'h1111)});
      @(posedge clk);
      #1 check_zero("reset");
      rst = 1'b0;
      mon_on = 1'b1;

      // Clean sweep: addresses 0..7, one pass_done, then wrap to 0.
      gnt_man = 1'b1;
      base = pass_seen;
      push_words(DEPTH + 1, 1'b1);
      enable = 1'b1;
      finish_run();
      chk("clean_pass_count", 64'(pass_seen - base), 64'd1);
      chk("clean_corr", 64'(corrected_count), 64'd0);
      chk("clean_uncorr", 64'(uncorrectable_count), 64'd0);

      // Correctable word at 3, uncorrectable at 5.
      load(3, {2'b01, 37'h12_3456_789A});
      load(5, rand_word(2));
      base = err_cycles;
      push_words(DEPTH, 1'b1);
      enable = 1'b1;
      finish_run();
      chk("dir_corr_count", 64'(corrected_count), 64'd1);
      chk("dir_uncorr_count", 64'(uncorrectable_count), 64'd1);
      chk("dir_last_err", 64'(last_error_addr), 64'd5);
      chk("dir_mem3", 64'(mem[3]), 64'h12_3456_789A);
      chk("dir_err_pulse_cycles", 64'(err_cycles - base), 64'd1);

      // Grant withdrawn for 4 cycles in READ and again in WRITE.
      load(ref_ptr, rand_word(1));
      gnt_man = 1'b0;
      push_words(1, 1'b0);
      enable = 1'b1;
      n = 0;
      do begin @(posedge clk); #1 n++; end while (!mem_req && n < 50);
      enable = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("read_wait_strobes", 64'({mem_req, mem_clk_en, mem_write_en}), 64'b100);
      end
      @(posedge clk); #1 gnt_man = 1'b1;
      @(posedge clk); #1 gnt_man = 1'b0;
      repeat (2) begin
         @(posedge clk); #1 chk("check_lock_req", 64'(mem_req), 64'd1);
      end
      repeat (4) begin
         @(negedge clk);
         chk("write_wait_strobes", 64'({mem_req, mem_clk_en, mem_write_en}), 64'b100);
      end
      @(posedge clk); #1 gnt_man = 1'b1;
      finish_run();

      // interval=10, enable dropped while WRITE waits for the grant.
      interval = 16'd10;
      load(ref_ptr, rand_word(1));
      push_words(1, 1'b0);
      enable = 1'b1;
      wait_read(ok);
      @(posedge clk); #1 gnt_man = 1'b0;
      @(posedge clk);
      @(posedge clk); #1 enable = 1'b0;
      @(posedge clk); #1 gnt_man = 1'b1;
      finish_run();
      any = 0;
      repeat (20) begin @(negedge clk); any |= mem_req; end
      chk("disabled_no_req", 64'(any), 64'd0);
      push_words(1, 1'b0);
      @(posedge clk); #1 enable = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_clk_en && n < 40);
      chk("interval_latency", 64'(n), 64'd12);
      @(posedge clk); #1 enable = 1'b0;
      finish_run();
      interval = '0;

      // Reset during CHECK, then during WRITE with grant high.
      a = ref_ptr;
      load(a, rand_word(1));
      orig = mem[a];
      push_words(1, 1'b0);
      enable = 1'b1;
      wait_read(ok);
      @(posedge clk); #1 rst = 1'b1; enable = 1'b0;
      model_reset();
      @(posedge clk); #1 check_zero("rst_check");
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("rst_check_no_write", 64'(mem[a]), 64'(orig));

      load(0, rand_word(1));
      orig = mem[0];
      push_words(1, 1'b0);
      enable = 1'b1;
      wait_read(ok);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b1; enable = 1'b0;
      model_reset();
      @(posedge clk); #1 check_zero("rst_write");
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("rst_write_no_write", 64'(mem[0]), 64'(orig));
      push_words(DEPTH, 1'b1);
      enable = 1'b1;
      finish_run();

      // Randomized rounds with random grant and interval; counters reach saturation.
      for (int r = 0; r < 6; r++) begin
         interval = IW'($urandom_range(0, 3));
         for (int i = 0; i < DEPTH; i++) begin
            n = $urandom_range(0, 9);
            load(i, rand_word(n < 3 ? 0 : n < 7 ? 1 : n == 7 ? 2 : n == 8 ? 3 : 0));
         end
         push_words(2 * DEPTH, 1'b0);
         gnt_rand = 1'b1;
         enable = 1'b1;
         finish_run();
         gnt_rand = 1'b0;
      end
      chk("final_corr", 64'(corrected_count), 64'(exp_cor));
      chk("final_uncorr", 64'(uncorrectable_count), 64'(exp_unc));
      for (int i = 0; i < DEPTH; i++) chk("final_mem", 64'(mem[i]), 64'(ref_mem[i]));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
